// File: rtl/traffic_intersection_ctrl.sv
// ---------------------------------------------------------------------------
// traffic_intersection_ctrl
//
// Two-road (main/side) intersection controller. Main road rests in green until
// a side vehicle, a pedestrian or night mode asks for service. Every change of
// right-of-way passes through an all-red clearance. Pedestrians get a dedicated
// walk phase, and night mode flashes main yellow / side red.
//
// All timing is counted in cycles where tick=1. A state with duration D loads
// D-1 on entry and exits on the tick that finds the timer at 0.
//
// Ports:
//   clk         in   1   clock, rising edge
//   rst         in   1   asynchronous reset, active-low
//   tick        in   1   timebase strobe; timer and state advance only on tick
//   side_sense  in   1   side-road vehicle present (level)
//   ped_req     in   1   pedestrian request (level or pulse)
//   night       in   1   night flashing-mode request
//   main_light  out  2   00 red, 01 yellow, 10 green, 11 dark
//   side_light  out  2   same encoding as main_light
//   walk        out  1   pedestrian walk lamp
//   phase       out  3   current state encoding
//   timer       out  TW  ticks remaining in the current phase, minus 1
// ---------------------------------------------------------------------------
module traffic_intersection_ctrl #(
  parameter int TW       = 8,
  parameter int GREEN_T  = 10,
  parameter int YELLOW_T = 5,
  parameter int ALLRED_T = 2,
  parameter int PED_T    = 8,
  parameter int FLASH_T  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          side_sense,
  input  logic          ped_req,
  input  logic          night,
  output logic [1:0]    main_light,
  output logic [1:0]    side_light,
  output logic          walk,
  output logic [2:0]    phase,
  output logic [TW-1:0] timer
);

  localparam logic [2:0] MAIN_G   = 3'd0;
  localparam logic [2:0] MAIN_Y   = 3'd1;
  localparam logic [2:0] ALLRED1  = 3'd2;
  localparam logic [2:0] SIDE_G   = 3'd3;
  localparam logic [2:0] SIDE_Y   = 3'd4;
  localparam logic [2:0] ALLRED2  = 3'd5;
  localparam logic [2:0] PED_WALK = 3'd6;
  localparam logic [2:0] FLASH    = 3'd7;

  localparam logic [1:0] LT_RED  = 2'b00;
  localparam logic [1:0] LT_YEL  = 2'b01;
  localparam logic [1:0] LT_GRN  = 2'b10;
  localparam logic [1:0] LT_DARK = 2'b11;

  // A zero duration behaves like a one-tick duration, so its load value is 0.
  localparam logic [TW-1:0] GREEN_LD  = (GREEN_T  <= 1) ? '0 : TW'(GREEN_T  - 1);
  localparam logic [TW-1:0] YELLOW_LD = (YELLOW_T <= 1) ? '0 : TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] ALLRED_LD = (ALLRED_T <= 1) ? '0 : TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] PED_LD    = (PED_T    <= 1) ? '0 : TW'(PED_T    - 1);
  localparam logic [TW-1:0] FLASH_LD  = (FLASH_T  <= 1) ? '0 : TW'(FLASH_T  - 1);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [TW-1:0] timer_nxt;
  logic          flash_lit;
  logic          lit_nxt;
  logic          side_pend;
  logic          ped_pend;
  logic          side_nxt;
  logic          ped_nxt;
  logic          enter_side;
  logic          enter_ped;

  // Timer value loaded when a state is entered.
  function automatic logic [TW-1:0] load_for(input logic [2:0] s);
    logic [TW-1:0] v;
    v = ALLRED_LD;
    case (s)
      MAIN_G, SIDE_G: v = GREEN_LD;
      MAIN_Y, SIDE_Y: v = YELLOW_LD;
      PED_WALK:       v = PED_LD;
      FLASH:          v = FLASH_LD;
      default:        v = ALLRED_LD;
    endcase
    return v;
  endfunction

  // Lamp pattern {main, side, walk} for a state; lit selects the flash half.
  function automatic logic [4:0] lamps_for(input logic [2:0] s, input logic lit);
    logic [4:0] l;
    l = {LT_RED, LT_RED, 1'b0};
    case (s)
      MAIN_G:   l = {LT_GRN, LT_RED, 1'b0};
      MAIN_Y:   l = {LT_YEL, LT_RED, 1'b0};
      SIDE_G:   l = {LT_RED, LT_GRN, 1'b0};
      SIDE_Y:   l = {LT_RED, LT_YEL, 1'b0};
      PED_WALK: l = {LT_RED, LT_RED, 1'b1};
      FLASH:    l = lit ? {LT_YEL, LT_RED, 1'b0} : {LT_DARK, LT_DARK, 1'b0};
      default:  l = {LT_RED, LT_RED, 1'b0};
    endcase
    return l;
  endfunction

  // Next-state and timer logic. Nothing moves without a tick. While the timer
  // is non-zero it just counts down; at zero the state decides where to go.
  // MAIN_G with no demand stays put with the timer parked at 0, and FLASH
  // reloads itself and flips its lamp half each half-period while night holds.
  // Any real state change reloads the timer for the new state and starts the
  // flash pattern on its lit half.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    lit_nxt   = flash_lit;
    if (tick) begin
      if (timer != '0) begin
        timer_nxt = timer - TW'(1);
      end else begin
        case (state)
          MAIN_G: begin
            if (night || side_pend || ped_pend) state_nxt = MAIN_Y;
          end
          MAIN_Y: state_nxt = ALLRED1;
          ALLRED1: begin
            if (night)          state_nxt = FLASH;
            else if (side_pend) state_nxt = SIDE_G;
            else if (ped_pend)  state_nxt = PED_WALK;
            else                state_nxt = MAIN_G;
          end
          SIDE_G: state_nxt = SIDE_Y;
          SIDE_Y: state_nxt = ALLRED2;
          ALLRED2: begin
            if (ped_pend) state_nxt = PED_WALK;
            else          state_nxt = MAIN_G;
          end
          PED_WALK: state_nxt = MAIN_G;
          FLASH: begin
            if (!night) begin
              state_nxt = ALLRED2;
            end else begin
              timer_nxt = FLASH_LD;
              lit_nxt   = ~flash_lit;
            end
          end
          default: state_nxt = ALLRED2;
        endcase
        if (state_nxt != state) begin
          timer_nxt = load_for(state_nxt);
          lit_nxt   = 1'b1;
        end
      end
    end
  end

  // Demand latches capture requests on every cycle, tick or not. Entering the
  // serving phase clears the latch, and that clear beats a simultaneous set.
  // A pedestrian request made while walk is already showing is dropped.
  always_comb begin
    enter_side = (state_nxt == SIDE_G)   && (state != SIDE_G);
    enter_ped  = (state_nxt == PED_WALK) && (state != PED_WALK);
    side_nxt   = (side_pend | side_sense) & ~enter_side;
    ped_nxt    = (ped_pend | (ped_req & (state != PED_WALK))) & ~enter_ped;
  end

  // State, timer, latches and lamps are all registered. Lamps are decoded from
  // the next state so they change on the same edge as phase. Reset lands in
  // the second all-red clearance so power-up starts with a clean handover.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ALLRED2;
      timer      <= ALLRED_LD;
      flash_lit  <= 1'b0;
      side_pend  <= 1'b0;
      ped_pend   <= 1'b0;
      main_light <= LT_RED;
      side_light <= LT_RED;
      walk       <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      flash_lit <= lit_nxt;
      side_pend <= side_nxt;
      ped_pend  <= ped_nxt;
      {main_light, side_light, walk} <= lamps_for(state_nxt, lit_nxt);
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// ---------------------------------------------------------------------------
// tb_traffic_intersection_ctrl
//
// Directed bench for traffic_intersection_ctrl. Expected per-cycle outputs
// {phase, main, side, walk, timer} are queued as each scenario is set up and
// popped one per clock, #1 after the rising edge.
// ---------------------------------------------------------------------------
module tb_traffic_intersection_ctrl;

  localparam int TW = 8;

  localparam logic [2:0] MAIN_G   = 3'd0;
  localparam logic [2:0] MAIN_Y   = 3'd1;
  localparam logic [2:0] ALLRED1  = 3'd2;
  localparam logic [2:0] SIDE_G   = 3'd3;
  localparam logic [2:0] SIDE_Y   = 3'd4;
  localparam logic [2:0] ALLRED2  = 3'd5;
  localparam logic [2:0] PED_WALK = 3'd6;
  localparam logic [2:0] FLASH    = 3'd7;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic          side_sense;
  logic          ped_req;
  logic          night;
  logic [1:0]    main_light;
  logic [1:0]    side_light;
  logic          walk;
  logic [2:0]    phase;
  logic [TW-1:0] timer;

  int checks  = 0;
  int errors  = 0;
  int tickDiv = 1;
  int cyc     = 0;

  logic [15:0] expQ[$];
  string       tagQ[$];

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  traffic_intersection_ctrl #(
    .TW(TW), .GREEN_T(10), .YELLOW_T(5), .ALLRED_T(2), .PED_T(8), .FLASH_T(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .side_sense (side_sense),
    .ped_req    (ped_req),
    .night      (night),
    .main_light (main_light),
    .side_light (side_light),
    .walk       (walk),
    .phase      (phase),
    .timer      (timer)
  );

  // Queue one expected output vector with a short tag.
  task automatic pushExp(input logic [2:0] ph, input logic [1:0] ml, input logic [1:0] sl,
                         input logic wk, input logic [TW-1:0] tm, input string tag);
    expQ.push_back({ph, ml, sl, wk, tm});
    tagQ.push_back(tag);
  endtask

  // Queue a phase that counts its timer down from start over nVals values,
  // each value held for per clocks. Lamps follow the fixed per-phase table.
  task automatic expectRun(input logic [2:0] ph, input int nVals, input int start,
                           input int per, input string tag);
    logic [1:0] ml;
    logic [1:0] sl;
    ml = 2'b00;
    sl = 2'b00;
    case (ph)
      MAIN_G:  ml = 2'b10;
      MAIN_Y:  ml = 2'b01;
      SIDE_G:  sl = 2'b10;
      SIDE_Y:  sl = 2'b01;
      default: ;
    endcase
    for (int v = 0; v < nVals; v++)
      for (int r = 0; r < per; r++)
        pushExp(ph, ml, sl, (ph == PED_WALK), TW'(start - v), tag);
  endtask

  // Pop the next expectation and compare it with the DUT outputs.
  task automatic checkOutput();
    logic [15:0] obs;
    logic [15:0] expv;
    string       tag;
    obs = {phase, main_light, side_light, walk, timer};
    checks++;
    assert (expQ.size() != 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_empty observed %h expected queued entry", obs);
    end
    if (expQ.size() != 0) begin
      expv = expQ.pop_front();
      tag  = tagQ.pop_front();
      assert (obs === expv) else begin
        errors++;
        $error("[TB] FAIL %s observed phase=%0d main=%b side=%b walk=%b timer=%0d expected phase=%0d main=%b side=%b walk=%b timer=%0d",
               tag, obs[15:13], obs[12:11], obs[10:9], obs[8], obs[7:0],
               expv[15:13], expv[12:11], expv[10:9], expv[8], expv[7:0]);
      end
    end
  endtask

  // Drive the demand inputs for the following clocks.
  task automatic applyStimulus(input logic s, input logic p, input logic n);
    side_sense = s;
    ped_req    = p;
    night      = n;
  endtask

  // Advance n clocks, generating tick from tickDiv, and check each cycle.
  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick = (tickDiv <= 1) ? 1'b1 : ((cyc % tickDiv) == 0);
      @(posedge clk);
      #1;
      checkOutput();
      cyc++;
    end
  endtask

  initial begin
    rst = 1'b0;
    tick = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Reset state, then idle power-up into main green rest.
    #12;
    pushExp(ALLRED2, 2'b00, 2'b00, 1'b0, 8'd1, "reset_state");
    checkOutput();
    @(negedge clk);
    rst = 1'b1;
    $display("[TB] idle power-up");
    expectRun(ALLRED2, 1, 0, 1, "pwrup_allred2");
    expectRun(MAIN_G, 10, 9, 1, "pwrup_main_g");
    expectRun(MAIN_G, 1, 0, 8, "main_rest");
    runCycles(19);

    // Side vehicle pulse: full side service, latch cleared afterwards.
    $display("[TB] side vehicle");
    expectRun(MAIN_G, 1, 0, 1, "side_capture");
    expectRun(MAIN_Y, 5, 4, 1, "side_main_y");
    expectRun(ALLRED1, 2, 1, 1, "side_allred1");
    expectRun(SIDE_G, 10, 9, 1, "side_side_g");
    expectRun(SIDE_Y, 5, 4, 1, "side_side_y");
    expectRun(ALLRED2, 2, 1, 1, "side_allred2");
    expectRun(MAIN_G, 10, 9, 1, "side_back_main");
    expectRun(MAIN_G, 1, 0, 3, "side_rest");
    applyStimulus(1'b1, 1'b0, 1'b0);
    runCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    runCycles(37);

    // Pedestrian pulse only.
    $display("[TB] pedestrian only");
    expectRun(MAIN_G, 1, 0, 1, "ped_capture");
    expectRun(MAIN_Y, 5, 4, 1, "ped_main_y");
    expectRun(ALLRED1, 2, 1, 1, "ped_allred1");
    expectRun(PED_WALK, 8, 7, 1, "ped_walk");
    expectRun(MAIN_G, 10, 9, 1, "ped_back_main");
    expectRun(MAIN_G, 1, 0, 3, "ped_rest");
    applyStimulus(1'b0, 1'b1, 1'b0);
    runCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    runCycles(28);

    // Side and pedestrian together; a request during walk is ignored.
    $display("[TB] side plus pedestrian");
    expectRun(MAIN_G, 1, 0, 1, "both_capture");
    expectRun(MAIN_Y, 5, 4, 1, "both_main_y");
    expectRun(ALLRED1, 2, 1, 1, "both_allred1");
    expectRun(SIDE_G, 10, 9, 1, "both_side_g");
    expectRun(SIDE_Y, 5, 4, 1, "both_side_y");
    expectRun(ALLRED2, 2, 1, 1, "both_allred2");
    expectRun(PED_WALK, 8, 7, 1, "both_walk");
    expectRun(MAIN_G, 10, 9, 1, "both_back_main");
    expectRun(MAIN_G, 1, 0, 3, "no_second_walk");
    applyStimulus(1'b1, 1'b1, 1'b0);
    runCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    runCycles(27);
    applyStimulus(1'b0, 1'b1, 1'b0);
    runCycles(2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    runCycles(16);

    // Night mode: flash alternates each tick, leaves via ALLRED2.
    $display("[TB] night flash");
    expectRun(MAIN_Y, 5, 4, 1, "night_main_y");
    expectRun(ALLRED1, 2, 1, 1, "night_allred1");
    for (int k = 0; k < 3; k++) begin
      pushExp(FLASH, 2'b01, 2'b00, 1'b0, 8'd0, "flash_lit");
      pushExp(FLASH, 2'b11, 2'b11, 1'b0, 8'd0, "flash_dark");
    end
    expectRun(ALLRED2, 2, 1, 1, "night_allred2");
    expectRun(MAIN_G, 10, 9, 1, "night_back_main");
    expectRun(MAIN_G, 1, 0, 2, "night_rest");
    applyStimulus(1'b0, 1'b0, 1'b1);
    runCycles(13);
    applyStimulus(1'b0, 1'b0, 1'b0);
    runCycles(14);

    // Slow timebase: async reset mid-phase, durations x4, reset mid side green.
    $display("[TB] slow tick and async reset");
    #2;
    rst = 1'b0;
    #1;
    pushExp(ALLRED2, 2'b00, 2'b00, 1'b0, 8'd1, "async_reset_main");
    checkOutput();
    @(negedge clk);
    rst = 1'b1;
    tickDiv = 4;
    cyc = 0;
    expectRun(ALLRED2, 1, 0, 4, "slow_allred2");
    expectRun(MAIN_G, 10, 9, 4, "slow_main_g");
    expectRun(MAIN_Y, 5, 4, 4, "slow_main_y");
    expectRun(ALLRED1, 2, 1, 4, "slow_allred1");
    expectRun(SIDE_G, 5, 9, 4, "slow_side_g");
    runCycles(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    runCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    runCycles(90);
    #2;
    rst = 1'b0;
    #1;
    pushExp(ALLRED2, 2'b00, 2'b00, 1'b0, 8'd1, "async_reset_side_g");
    checkOutput();
    @(negedge clk);
    rst = 1'b1;
    tickDiv = 1;
    cyc = 0;
    expectRun(ALLRED2, 1, 0, 1, "post_reset_allred2");
    expectRun(MAIN_G, 2, 9, 1, "post_reset_main_g");
    runCycles(3);

    checks++;
    assert (expQ.size() == 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_drain observed %0d leftover expected 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
